apb_master_arbiter: RTL and testbench

//  Two-requester APB master that shares one APB bus (LED/SW1/SW2/SEG peripheral window) between requesters 0 and 1.

---
 rtl/apb_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 33 +++
 rtl/apb_master_arbiter.sv | 146 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and constants for the two-requester APB master
package apb_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam logic [APB_DW-1:0] ERR_RDATA = 32'h0;

  function automatic logic addr_in_window(input logic [APB_AW-1:0] addr,
                                          input logic [APB_AW-1:0] base,
                                          input logic [APB_AW-1:0] mask);
    return (addr & ~mask) == base;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; grant is combinational, history is registered
module rr_arb2 (
  input  logic       Pclk,
  input  logic       Prst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  // Reset value 1 lets requester 0 win the first tie.
  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge Pclk or negedge Prst_n) begin
    if (!Prst_n) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - shares one APB bus between two requesters with decode and timeout errors
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h2000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'h0000_000F,
  parameter int          TIMEOUT_CYC = 16,
  parameter int          TO_W        = 5
) (
  input  logic        Pclk,
  input  logic        Prst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic        req0_write,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic        req1_write,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] Paddr,
  output logic        Pwrite,
  output logic        Psel,
  output logic        Penable,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata,
  input  logic        Pready,
  input  logic        Pslverr
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t             state;
  logic   [1:0]       gnt;
  logic               cap_id;
  logic   [TO_W-1:0]  to_cnt;
  logic   [APB_DW-1:0] rsp_rdata;
  logic               rsp_err;

  logic   [APB_AW-1:0] sel_addr;
  logic                sel_write;
  logic   [APB_DW-1:0] sel_wdata;

  rr_arb2 u_arb (
    .Pclk   (Pclk),
    .Prst_n (Prst_n),
    .req    ({req1_valid, req0_valid}),
    .enable (state == IDLE),
    .gnt    (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign sel_addr  = gnt[1] ? req1_addr  : req0_addr;
  assign sel_write = gnt[1] ? req1_write : req0_write;
  assign sel_wdata = gnt[1] ? req1_wdata : req0_wdata;

  // Response data is shared; each requester only looks at it while its own valid is high.
  assign rsp0_rdata = rsp_rdata;
  assign rsp1_rdata = rsp_rdata;
  assign rsp0_err   = rsp_err;
  assign rsp1_err   = rsp_err;

  always_ff @(posedge Pclk or negedge Prst_n) begin
    if (!Prst_n) begin
      state      <= IDLE;
      Psel       <= 1'b0;
      Penable    <= 1'b0;
      Pwrite     <= 1'b0;
      Paddr      <= '0;
      Pwdata     <= '0;
      cap_id     <= 1'b0;
      to_cnt     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            cap_id <= gnt[1];
            if (addr_in_window(sel_addr, ADDR_BASE, ADDR_MASK)) begin
              state   <= SETUP;
              Psel    <= 1'b1;
              Penable <= 1'b0;
              Paddr   <= sel_addr;
              Pwrite  <= sel_write;
              Pwdata  <= sel_wdata;
            end else begin
              // Decode miss never touches the bus.
              state      <= RESP;
              rsp0_valid <= gnt[0];
              rsp1_valid <= gnt[1];
              rsp_rdata  <= ERR_RDATA;
              rsp_err    <= 1'b1;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          Penable <= 1'b1;
          to_cnt  <= '0;
        end
        ACCESS: begin
          if (Pready) begin
            state      <= RESP;
            Psel       <= 1'b0;
            Penable    <= 1'b0;
            rsp0_valid <= ~cap_id;
            rsp1_valid <= cap_id;
            rsp_err    <= Pslverr;
            rsp_rdata  <= (Pwrite || Pslverr) ? ERR_RDATA : Prdata;
          end else if (to_cnt == TO_LAST) begin
            state      <= RESP;
            Psel       <= 1'b0;
            Penable    <= 1'b0;
            rsp0_valid <= ~cap_id;
            rsp1_valid <= cap_id;
            rsp_err    <= 1'b1;
            rsp_rdata  <= ERR_RDATA;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          rsp_rdata  <= '0;
          rsp_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - scoreboard bench for apb_master_arbiter
module tb_apb_master_arbiter;

  logic        Pclk = 0;
  logic        Prst_n = 0;
  logic        req0_valid = 0, req0_write = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0;
  logic        req1_valid = 0, req1_write = 0;
  logic [31:0] req1_addr = 0, req1_wdata = 0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] Paddr, Pwdata, Prdata;
  logic        Pwrite, Psel, Penable, Pready, Pslverr;

  int total = 0;
  int bad = 0;

  // Slave model configuration
  int          slv_delay = 0;
  bit          slv_stuck = 0;
  logic [31:0] slv_rdata = 0;
  bit          slv_err = 0;
  int          wait_cnt = 0;
  int          psel_cnt = 0;
  int          penable_cnt = 0;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  apb_master_arbiter dut (
    .Pclk(Pclk), .Prst_n(Prst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_write(req0_write), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_write(req1_write), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .Paddr(Paddr), .Pwrite(Pwrite), .Psel(Psel), .Penable(Penable), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  always #5 Pclk = ~Pclk;

  assign Pready  = !slv_stuck && (wait_cnt >= slv_delay);
  assign Prdata  = slv_rdata;
  assign Pslverr = slv_err;

  always @(posedge Pclk) begin
    if (Psel && Penable && !Pready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (Psel) psel_cnt <= psel_cnt + 1;
    if (Penable) penable_cnt <= penable_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse pops the next expectation.
  always @(negedge Pclk) begin
    if (Prst_n && (rsp0_valid || rsp1_valid)) begin
      chk("rsp_both_valid", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
      chk("rsp_psel_low", {31'd0, Psel}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", rsp1_valid ? 32'd1 : 32'd0, e.id);
        chk("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp1_valid ? rsp1_err : rsp0_err}, {31'd0, e.err});
      end
    end
  end

  task automatic expect_rsp(input int id, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.id = id; e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic send(input int id, input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    int n = 0;
    bit got = 0;
    if (id == 0) begin
      req0_addr = addr; req0_write = wr; req0_wdata = wd; req0_valid = 1;
    end else begin
      req1_addr = addr; req1_write = wr; req1_wdata = wd; req1_valid = 1;
    end
    while (!got && n < 200) begin
      @(negedge Pclk);
      got = (id == 0) ? req0_ready : req1_ready;
      n++;
    end
    chk("handshake", {31'd0, got}, 32'd1);
    @(posedge Pclk); #1;
    if (id == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge Pclk);
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
    @(posedge Pclk); #1;
  endtask

  task automatic do_reset();
    @(posedge Pclk); #1;
    Prst_n = 0;
    repeat (2) @(posedge Pclk);
    #1 Prst_n = 1;
  endtask

  initial begin
    int p0, e0;
    // Reset state
    #12;
    chk("rst_psel", {31'd0, Psel}, 32'd0);
    chk("rst_penable", {31'd0, Penable}, 32'd0);
    chk("rst_pwrite", {31'd0, Pwrite}, 32'd0);
    chk("rst_paddr", Paddr, 32'd0);
    chk("rst_pwdata", Pwdata, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_rsp_err", {30'd0, rsp1_err, rsp0_err}, 32'd0);
    chk("rst_rsp_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge Pclk); #1 Prst_n = 1;

    // 1: write with zero-wait slave, cycle-exact timing
    expect_rsp(0, 32'h0, 1'b0);
    send(0, 32'h2000_0000, 1'b1, 32'hDEAD_BEEF);
    @(negedge Pclk);
    chk("t1_setup_psel", {31'd0, Psel}, 32'd1);
    chk("t1_setup_penable", {31'd0, Penable}, 32'd0);
    chk("t1_paddr", Paddr, 32'h2000_0000);
    chk("t1_pwrite", {31'd0, Pwrite}, 32'd1);
    @(negedge Pclk);
    chk("t1_access_penable", {31'd0, Penable}, 32'd1);
    chk("t1_pwdata", Pwdata, 32'hDEAD_BEEF);
    @(negedge Pclk);
    chk("t1_rsp0_at_t3", {31'd0, rsp0_valid}, 32'd1);
    drain();

    // 2: simultaneous reads; round-robin from a fresh reset
    do_reset();
    slv_rdata = 32'h0000_1234;
    expect_rsp(0, 32'h1234, 1'b0);
    expect_rsp(1, 32'h1234, 1'b0);
    fork
      send(0, 32'h2000_0004, 1'b0, 32'h0);
      send(1, 32'h2000_0004, 1'b0, 32'h0);
    join
    drain();
    expect_rsp(0, 32'h1234, 1'b0);
    expect_rsp(1, 32'h1234, 1'b0);
    fork
      send(0, 32'h2000_0004, 1'b0, 32'h0);
      send(1, 32'h2000_0004, 1'b0, 32'h0);
    join
    drain();

    // 3: decode miss responds next cycle with no bus activity
    p0 = psel_cnt;
    expect_rsp(1, 32'h0, 1'b1);
    send(1, 32'h3000_0000, 1'b0, 32'h0);
    @(negedge Pclk);
    chk("t3_rsp1_next", {31'd0, rsp1_valid}, 32'd1);
    drain();
    chk("t3_no_psel", psel_cnt - p0, 32'd0);

    // 4: three wait states, then a hung slave
    slv_rdata = 32'h55;
    slv_delay = 3;
    e0 = penable_cnt;
    expect_rsp(0, 32'h55, 1'b0);
    send(0, 32'h2000_000C, 1'b0, 32'h0);
    drain();
    chk("t4_penable_cycles", penable_cnt - e0, 32'd4);
    slv_stuck = 1;
    e0 = penable_cnt;
    expect_rsp(0, 32'h0, 1'b1);
    send(0, 32'h2000_000C, 1'b0, 32'h0);
    drain();
    chk("t4_timeout_cycles", penable_cnt - e0, 32'd16);

    // 5: slave error, then reset during ACCESS
    slv_stuck = 0;
    slv_delay = 0;
    slv_err = 1;
    slv_rdata = 32'hAAAA_5555;
    expect_rsp(1, 32'h0, 1'b1);
    send(1, 32'h2000_0008, 1'b0, 32'h0);
    drain();
    slv_err = 0;
    slv_stuck = 1;
    send(1, 32'h2000_0004, 1'b0, 32'h0);
    @(posedge Pclk); #1;
    chk("t5_in_access", {31'd0, Penable}, 32'd1);
    Prst_n = 0;
    #1;
    chk("t5_psel_drop", {31'd0, Psel}, 32'd0);
    repeat (2) @(posedge Pclk);
    #1 Prst_n = 1;
    slv_stuck = 0;
    slv_rdata = 32'h0000_0077;
    expect_rsp(0, 32'h77, 1'b0);
    send(0, 32'h2000_0004, 1'b0, 32'h0);
    drain();
    repeat (25) @(posedge Pclk);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
